linebuf: RTL and testbench
==========================

LINEBUF -- requirements
Module: linebuf

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  LGFLEN  8  log2 of FIFO depth (depth 2^LGFLEN bytes).
  MAXLINE  80  uncommitted length that forces a commit; legal range 1 .. 2^LGFLEN-1.
  EOL_MODE  0  terminator set: 0 = CR (8'h0d) or LF (8'h0a); 1 = LF only; 2 = CR only.
  TIMEOUT  0  idle clocks before a partial line is committed; 0 disables the timeout.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  i_clk  in  1  the single clock.
  i_reset  in  1  synchronous, active-high reset.
  i_stb  in  1  receive strobe: one byte per asserted cycle.
  i_data  in  8  received byte, qualified by i_stb.
  o_stb  out  1  committed byte available to the transmitter.
  o_data  out  8  byte at the read pointer, valid while o_stb is high.
  i_busy  in  1  transmitter busy; a byte transfers when o_stb && !i_busy.
  o_fill  out  LGFLEN+1  bytes held in the FIFO.
  o_pending  out  LGFLEN+1  committed, not-yet-sent bytes.
  o_overflow  out  1  sticky flag: a byte was dropped.
REQ-003 The design SHALL use one clock, i_clk; reset SHALL be i_reset, synchronous and active-high.

Function
REQ-004 Storage SHALL be an internal circular FIFO with a write pointer, a read pointer and a commit pointer, each LGFLEN+1 bits and wrapping modulo 2^(LGFLEN+1).
REQ-005 A byte SHALL be written on i_stb when o_fill < 2^LGFLEN; o_fill SHALL increase by 1 on the following cycle.
REQ-006 On i_stb with o_fill == 2^LGFLEN:
  the byte SHALL be discarded;
  o_overflow SHALL set to 1 and stay 1 until reset.
REQ-007 A terminator is a byte in the EOL_MODE set. Writing a terminator SHALL set the commit pointer to the write pointer + 1, so the terminator itself is committed.
REQ-008 A dropped terminator (FIFO full) SHALL still move the commit pointer to the current write pointer.
REQ-009 Uncommitted length is the write pointer minus the commit pointer. When a write makes it equal MAXLINE, the commit pointer SHALL move to include that byte.
REQ-010 Timeout (TIMEOUT > 0):
  an idle counter SHALL clear on every i_stb;
  it SHALL increment, saturating at TIMEOUT, on each cycle without i_stb while uncommitted length is nonzero;
  when it reaches TIMEOUT, the commit pointer SHALL move to the write pointer and the counter SHALL clear.
REQ-011 Commit latency: a byte committed on the cycle of its write SHALL raise o_stb (if it was low) on the next cycle.
REQ-012 o_stb SHALL equal (read pointer != commit pointer).
REQ-013 o_data SHALL be the byte at the read pointer, stable while o_stb && i_busy.
REQ-014 On o_stb && !i_busy, the read pointer SHALL advance by 1 on the next edge.
REQ-015 A write and a read in the same cycle SHALL both complete; o_fill SHALL be unchanged.
REQ-016 o_pending SHALL be the commit pointer minus the read pointer.
REQ-017 o_pending SHALL never exceed o_fill.
REQ-018 Uncommitted bytes SHALL never be transmitted.
REQ-019 A commit pointer update and a read in the same cycle SHALL both take effect.
REQ-020 Wrap-around of every pointer past 2^(LGFLEN+1)-1 SHALL leave fill and pending arithmetic correct (modular subtraction).

Reset
REQ-021 While i_reset is high at a clock edge, all pointers and the idle counter SHALL clear to 0, and these outputs SHALL be 0 on the next cycle: o_stb, o_fill, o_pending, o_overflow.
REQ-022 Reset mid-line or mid-transmit SHALL discard all buffered bytes.
REQ-023 i_stb during reset SHALL be ignored.
REQ-024 o_data SHALL be don't-care while o_stb is 0.

Verification
REQ-025 A bench SHALL cover these directed scenarios:
  V1: defaults, i_busy=0, send "AB\n" -> o_stb low until the cycle after the 8'h0a write; then exactly 41,42,0a out; o_pending returns to 0.
  V2: 85 bytes with no terminator -> the 80th write commits 80 bytes; bytes 81-85 stay with o_pending=80 until the next commit.
  V3: TIMEOUT=16, write "xy" then idle -> o_stb rises 17 cycles after the last write; "xy" is sent.
  V4: i_busy=1, 257 bytes with LGFLEN=8 and MAXLINE=255 -> o_fill=256, o_overflow=1, 257th byte absent from the output.
  V5: continuous traffic over more than 600 bytes with random i_busy -> the output byte sequence equals the input; pointers wrap correctly.
  V6: i_reset asserted with o_pending=10 -> next cycle o_stb=0, o_fill=0, o_overflow=0; the next line is delivered intact.

Source files
------------

// File: rtl/linebuf.sv
// Line-committing byte FIFO: received bytes are held until a terminator,
// a MAXLINE-long run or an idle timeout commits them for transmission.
module linebuf #(
    parameter int LGFLEN   = 8,
    parameter int MAXLINE  = 80,
    parameter int EOL_MODE = 0,
    parameter int TIMEOUT  = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_stb,
    input  logic [7:0]        i_data,
    output logic              o_stb,
    output logic [7:0]        o_data,
    input  logic              i_busy,
    output logic [LGFLEN:0]   o_fill,
    output logic [LGFLEN:0]   o_pending,
    output logic              o_overflow
);

    localparam int DEPTH = 1 << LGFLEN;
    localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [LGFLEN:0] MAXL = (LGFLEN + 1)'(MAXLINE);
    localparam logic [TW-1:0]   TMO  = TW'(TIMEOUT);

    logic [7:0]      mem_q [DEPTH];
    logic [LGFLEN:0] wr_q, wr_d;
    logic [LGFLEN:0] rd_q, rd_d;
    logic [LGFLEN:0] cm_q, cm_d;
    logic [TW-1:0]   idle_q, idle_d;
    logic            ovf_q, ovf_d;

    logic            eol;
    logic            full;
    logic            wr_en;
    logic            rd_en;
    logic [LGFLEN:0] fill;
    logic [LGFLEN:0] unc_next;

    assign fill     = wr_q - rd_q;
    assign full     = fill[LGFLEN];
    assign wr_en    = i_stb && !full;
    assign rd_en    = o_stb && !i_busy;
    assign unc_next = wr_q + 1'b1 - cm_q;

    always_comb begin
        eol = 1'b0;
        if (EOL_MODE == 1)
            eol = (i_data == 8'h0a);
        else if (EOL_MODE == 2)
            eol = (i_data == 8'h0d);
        else
            eol = (i_data == 8'h0a) || (i_data == 8'h0d);
    end

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        cm_d   = cm_q;
        idle_d = idle_q;
        ovf_d  = ovf_q;
        if (rd_en)
            rd_d = rd_q + 1'b1;
        if (i_stb) begin
            idle_d = '0;
            if (wr_en) begin
                wr_d = wr_q + 1'b1;
                if (eol || unc_next == MAXL)
                    cm_d = wr_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
                // the terminator is lost, but the line before it still closes
                if (eol)
                    cm_d = wr_q;
            end
        end else if (TIMEOUT > 0) begin
            if (idle_q == TMO) begin
                cm_d   = wr_q;
                idle_d = '0;
            end else if (wr_q != cm_q) begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cm_q   <= '0;
            idle_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cm_q   <= cm_d;
            idle_q <= idle_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en && !i_reset)
            mem_q[wr_q[LGFLEN-1:0]] <= i_data;
    end

    assign o_stb      = (rd_q != cm_q);
    assign o_data     = mem_q[rd_q[LGFLEN-1:0]];
    assign o_fill     = fill;
    assign o_pending  = cm_q - rd_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_linebuf.sv
// Directed bench for linebuf: three instances cover the default,
// timeout and overflow configurations.
module tb_linebuf;

    logic       clk = 1'b0;
    logic       rst;
    logic       stb   [3];
    logic [7:0] dat   [3];
    logic       busy  [3];
    logic       ostb  [3];
    logic [7:0] odata [3];
    logic [8:0] fill  [3];
    logic [8:0] pend  [3];
    logic       ovf   [3];

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] got [$];
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    linebuf u0 (
        .i_clk(clk), .i_reset(rst), .i_stb(stb[0]), .i_data(dat[0]),
        .o_stb(ostb[0]), .o_data(odata[0]), .i_busy(busy[0]),
        .o_fill(fill[0]), .o_pending(pend[0]), .o_overflow(ovf[0])
    );

    linebuf #(.TIMEOUT(16)) u1 (
        .i_clk(clk), .i_reset(rst), .i_stb(stb[1]), .i_data(dat[1]),
        .o_stb(ostb[1]), .o_data(odata[1]), .i_busy(busy[1]),
        .o_fill(fill[1]), .o_pending(pend[1]), .o_overflow(ovf[1])
    );

    linebuf #(.LGFLEN(8), .MAXLINE(255)) u2 (
        .i_clk(clk), .i_reset(rst), .i_stb(stb[2]), .i_data(dat[2]),
        .o_stb(ostb[2]), .o_data(odata[2]), .i_busy(busy[2]),
        .o_fill(fill[2]), .o_pending(pend[2]), .o_overflow(ovf[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int idx, input logic [7:0] b);
        stb[idx] = 1'b1;
        dat[idx] = b;
        tick();
        stb[idx] = 1'b0;
    endtask

    task automatic collect(input int idx, input int maxcyc);
        got.delete();
        busy[idx] = 1'b0;
        for (int c = 0; c < maxcyc; c++) begin
            if (ostb[idx])
                got.push_back(odata[idx]);
            tick();
        end
    endtask

    task automatic cmp_seq(input string tag);
        int bad;
        bad = 0;
        chk({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (got[i] !== exp_q[i])
                bad++;
        chk({tag, "_bytes"}, bad, 0);
    endtask

    initial begin
        int n;
        int sent;
        int len;
        for (int i = 0; i < 3; i++) begin
            stb[i]  = 1'b0;
            dat[i]  = 8'h00;
            busy[i] = 1'b0;
        end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_stb%0d", i), ostb[i], 0);
            chk($sformatf("rst_fill%0d", i), fill[i], 0);
            chk($sformatf("rst_pend%0d", i), pend[i], 0);
            chk($sformatf("rst_ovf%0d", i), ovf[i], 0);
        end

        // V1
        send(0, 8'h41);
        chk("v1_stb_a", ostb[0], 0);
        send(0, 8'h42);
        chk("v1_stb_b", ostb[0], 0);
        chk("v1_fill_b", fill[0], 2);
        send(0, 8'h0a);
        chk("v1_stb_eol", ostb[0], 1);
        chk("v1_pend_eol", pend[0], 3);
        collect(0, 8);
        exp_q = '{8'h41, 8'h42, 8'h0a};
        cmp_seq("v1");
        chk("v1_pend_end", pend[0], 0);
        chk("v1_fill_end", fill[0], 0);

        // V2
        busy[0] = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 79; i++) begin
            send(0, 8'h41 + 8'(i % 26));
            exp_q.push_back(8'h41 + 8'(i % 26));
        end
        chk("v2_pend79", pend[0], 0);
        send(0, 8'h41 + 8'(79 % 26));
        exp_q.push_back(8'h41 + 8'(79 % 26));
        chk("v2_pend80", pend[0], 80);
        for (int i = 80; i < 85; i++) begin
            send(0, 8'h41 + 8'(i % 26));
            exp_q.push_back(8'h41 + 8'(i % 26));
        end
        chk("v2_pend85", pend[0], 80);
        chk("v2_fill85", fill[0], 85);
        send(0, 8'h0d);
        exp_q.push_back(8'h0d);
        chk("v2_pend_eol", pend[0], 86);
        collect(0, 100);
        cmp_seq("v2");

        // V3
        send(1, "x");
        send(1, "y");
        chk("v3_fill", fill[1], 2);
        chk("v3_pend", pend[1], 0);
        n = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (ostb[1]) begin
                n = c;
                break;
            end
        end
        chk("v3_delay", n, 17);
        collect(1, 6);
        exp_q = '{8'h78, 8'h79};
        cmp_seq("v3");

        // V4
        busy[2] = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            send(2, 8'h30 + 8'(i % 64));
            exp_q.push_back(8'h30 + 8'(i % 64));
        end
        chk("v4_fill256", fill[2], 256);
        chk("v4_ovf_pre", ovf[2], 0);
        chk("v4_pend255", pend[2], 255);
        send(2, 8'h7e);
        chk("v4_ovf", ovf[2], 1);
        chk("v4_fill_full", fill[2], 256);
        send(2, 8'h0a);
        chk("v4_pend_drop_eol", pend[2], 256);
        collect(2, 270);
        cmp_seq("v4");
        chk("v4_ovf_sticky", ovf[2], 1);
        chk("v4_fill_end", fill[2], 0);

        // V5
        exp_q.delete();
        got.delete();
        sent = 0;
        len = 0;
        while (sent < 700) begin
            busy[0] = ($urandom_range(0, 9) < 3);
            if (ostb[0] && !busy[0])
                got.push_back(odata[0]);
            if ($urandom_range(0, 9) < 4) begin
                stb[0] = 1'b1;
                if (len >= 1 + int'($urandom_range(0, 18))) begin
                    dat[0] = 8'h0a;
                    len = 0;
                end else begin
                    dat[0] = 8'(32 + $urandom_range(0, 94));
                    len++;
                end
                exp_q.push_back(dat[0]);
                sent++;
            end else begin
                stb[0] = 1'b0;
            end
            tick();
        end
        stb[0] = 1'b1;
        dat[0] = 8'h0a;
        exp_q.push_back(8'h0a);
        busy[0] = ($urandom_range(0, 9) < 3);
        if (ostb[0] && !busy[0])
            got.push_back(odata[0]);
        tick();
        stb[0] = 1'b0;
        busy[0] = 1'b0;
        for (int c = 0; c < 400 && ostb[0]; c++) begin
            got.push_back(odata[0]);
            tick();
        end
        cmp_seq("v5");
        chk("v5_ovf", ovf[0], 0);
        chk("v5_fill", fill[0], 0);
        chk("v5_pend", pend[0], 0);

        // V6
        busy[0] = 1'b1;
        for (int i = 0; i < 9; i++)
            send(0, 8'h61 + 8'(i));
        send(0, 8'h0a);
        chk("v6_pend10", pend[0], 10);
        rst = 1'b1;
        stb[0] = 1'b1;
        dat[0] = 8'h0a;
        tick();
        rst = 1'b0;
        stb[0] = 1'b0;
        chk("v6_stb", ostb[0], 0);
        chk("v6_fill", fill[0], 0);
        chk("v6_pend", pend[0], 0);
        chk("v6_ovf", ovf[0], 0);
        chk("v6_ovf_u2", ovf[2], 0);
        busy[0] = 1'b0;
        send(0, "O");
        send(0, "K");
        send(0, 8'h0d);
        collect(0, 8);
        exp_q = '{8'h4f, 8'h4b, 8'h0d};
        cmp_seq("v6");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
